// File: rtl/uart_autobaud_ctrl_pkg.sv
// Shared definitions for the UART auto-baud controller: FSM encoding, defaults, tolerance helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_autobaud_ctrl_pkg;

  // Rx oversampling: the generator produces 2**OVS_LOG2 ticks per bit
  localparam int          OVS_LOG2_DEF         = 4;
  // 50 MHz clock, 115200 baud, 16x oversampling
  localparam logic [15:0] DEFAULT_BAUDRATE_DEF = 16'd27;
  // 0x55 gives five falling edges (start edge included) spanning 8 bit times
  localparam logic [2:0]  FALLS_PER_SYNC       = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_MEASURE    = 3'd2,
    ST_CHECK      = 3'd3,
    ST_LOCKED     = 3'd4,
    ST_FAIL       = 3'd5
  } state_t;

  // True when a segment length lies within +/- ref_len/4 of the reference.
  // Arguments are zero-extended counter values; counters are at most 32 bits.
  function automatic logic seg_in_tol(input logic [31:0] seg, input logic [31:0] ref_len);
    logic [31:0] diff;
    diff = (seg >= ref_len) ? (seg - ref_len) : (ref_len - seg);
    return diff <= (ref_len >> 2);
  endfunction

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Rx pad synchroniser: 2-FF metastability chain plus one history flop for edge detection.
// Latency: a pad change shows on rx_s/rise/fall after the second flop, 3 cycles to the consumer.
// Backpressure: none; pulses are single-cycle and never held.
module uart_rx_sync_edge (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Rx,
  output logic rx_s,
  output logic rise,
  output logic fall
);

  // sh[0], sh[1] synchronise; sh[2] holds the previous synchronised level
  logic [2:0] sh;

  // Shift the pad level through; idle-high reset so no spurious edge leaves reset
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) sh <= 3'b111;
    else        sh <= {sh[1:0], Rx};
  end

  assign rx_s = sh[1];
  assign rise = sh[1] & ~sh[2];
  assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Baud divisor controller: measures a 0x55 sync character or takes a host divisor.
// Latency: qualifying edge in cycle N -> CHECK in N+1 -> BaudRate/Locked/Baud_Update in N+2.
// Backpressure: none; Start is dropped while Busy, Manual_Load always wins.
module uart_autobaud_ctrl
  import uart_autobaud_ctrl_pkg::*;
#(
  parameter int          OVS_LOG2         = OVS_LOG2_DEF,
  parameter int          CNT_W            = 24,
  parameter logic [15:0] DEFAULT_BAUDRATE = DEFAULT_BAUDRATE_DEF
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Rx,
  input  logic        Start,
  input  logic        Manual_Load,
  input  logic [15:0] Manual_Baud,
  output logic [15:0] BaudRate,
  output logic        Baud_Update,
  output logic        Locked,
  output logic        Busy,
  output logic        Error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // Half of one bit time in generator-tick units, for round-to-nearest
  localparam logic [CNT_W:0]   DIV_RND = (CNT_W+1)'(1) << (2 + OVS_LOG2);
  localparam logic [CNT_W:0]   DIV_MAX = (CNT_W+1)'(16'hFFFF);

  state_t           state, state_nx;
  logic             rx_s, rise, fall;
  logic             edge_any, edge_fall;
  logic [CNT_W-1:0] total_cnt, seg_cnt, l0_len, seg_len;
  logic             l0_vld;
  logic [2:0]       fall_cnt;
  logic [CNT_W:0]   div_w;
  logic             cnt_sat, seg_ok, fifth_fall, div_ok;
  logic             lock_ev, fail_ev, arm_ev, clr_cnt;
  logic [15:0]      new_baud;

  uart_rx_sync_edge u_rx_sync (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Rx    (Rx),
    .rx_s  (rx_s),
    .rise  (rise),
    .fall  (fall)
  );

  // Edge classification: after an edge the synchronised level tells its direction
  assign edge_any   = rise | fall;
  assign edge_fall  = edge_any & ~rx_s;

  // Segment length including the edge cycle itself
  assign seg_len    = seg_cnt + CNT_ONE;
  assign cnt_sat    = (total_cnt == CNT_MAX) || (seg_cnt == CNT_MAX);
  // The first segment defines L0 and is not itself checked
  assign seg_ok     = !l0_vld || seg_in_tol(32'(seg_len), 32'(l0_len));
  assign fifth_fall = edge_fall && (fall_cnt == FALLS_PER_SYNC - 3'd1);

  // total covers 8 bits of 2**OVS_LOG2 ticks each; round to nearest
  assign div_w      = ({1'b0, total_cnt} + DIV_RND) >> (3 + OVS_LOG2);
  assign div_ok     = (div_w != '0) && (div_w <= DIV_MAX);

  // FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FSM next state; Manual_Load overrides everything, including Start
  always_comb begin
    state_nx = state;
    if (Manual_Load) begin
      state_nx = (Manual_Baud == 16'd0) ? ST_FAIL : ST_LOCKED;
    end else begin
      case (state)
        ST_IDLE, ST_LOCKED, ST_FAIL: if (Start) state_nx = ST_WAIT_START;
        ST_WAIT_START:               if (fall)  state_nx = ST_MEASURE;
        ST_MEASURE: begin
          if (cnt_sat)                 state_nx = ST_FAIL;
          else if (edge_any && !seg_ok) state_nx = ST_FAIL;
          else if (fifth_fall)         state_nx = ST_CHECK;
        end
        ST_CHECK:                    state_nx = div_ok ? ST_LOCKED : ST_FAIL;
        default:                     state_nx = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: Busy plus the strobes that update counters and status registers
  always_comb begin
    Busy     = (state == ST_WAIT_START) || (state == ST_MEASURE);
    lock_ev  = (Manual_Load && (Manual_Baud != 16'd0)) ||
               (!Manual_Load && (state == ST_CHECK) && div_ok);
    fail_ev  = (state_nx == ST_FAIL);
    arm_ev   = !Manual_Load && Start &&
               ((state == ST_IDLE) || (state == ST_LOCKED) || (state == ST_FAIL));
    clr_cnt  = !Manual_Load && (state == ST_WAIT_START) && fall;
    new_baud = Manual_Load ? Manual_Baud : div_w[15:0];
  end

  // Measurement counters: saturate at CNT_MAX, capture L0 on the first edge
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      total_cnt <= '0;
      seg_cnt   <= '0;
      l0_len    <= '0;
      l0_vld    <= 1'b0;
      fall_cnt  <= 3'd0;
    end else if (clr_cnt) begin
      total_cnt <= '0;
      seg_cnt   <= '0;
      l0_vld    <= 1'b0;
      fall_cnt  <= 3'd1;
    end else if ((state == ST_MEASURE) && !Manual_Load) begin
      if (total_cnt != CNT_MAX) total_cnt <= total_cnt + CNT_ONE;
      if (edge_any) begin
        seg_cnt <= '0;
        if (!l0_vld) begin
          l0_len <= seg_len;
          l0_vld <= 1'b1;
        end
        if (edge_fall) fall_cnt <= fall_cnt + 3'd1;
      end else if (seg_cnt != CNT_MAX) begin
        seg_cnt <= seg_cnt + CNT_ONE;
      end
    end
  end

  // Status and divisor registers; a load always pulses Baud_Update, even for the same value
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      BaudRate    <= DEFAULT_BAUDRATE;
      Baud_Update <= 1'b0;
      Locked      <= 1'b0;
      Error       <= 1'b0;
    end else begin
      Baud_Update <= 1'b0;
      if (lock_ev) begin
        BaudRate    <= new_baud;
        Baud_Update <= 1'b1;
        Locked      <= 1'b1;
        Error       <= 1'b0;
      end else if (fail_ev) begin
        Locked <= 1'b0;
        Error  <= 1'b1;
      end else if (arm_ev) begin
        Locked <= 1'b0;
        Error  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
module tb_uart_autobaud_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Rx;
  logic        Start;
  logic        Manual_Load;
  logic [15:0] Manual_Baud;
  logic [15:0] BaudRate;
  logic        Baud_Update;
  logic        Locked;
  logic        Busy;
  logic        Error;

  int n_total = 0;
  int n_bad   = 0;
  int upd_seen = 0;

  uart_autobaud_ctrl dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Rx          (Rx),
    .Start       (Start),
    .Manual_Load (Manual_Load),
    .Manual_Baud (Manual_Baud),
    .BaudRate    (BaudRate),
    .Baud_Update (Baud_Update),
    .Locked      (Locked),
    .Busy        (Busy),
    .Error       (Error)
  );

  // 50 MHz
  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n falling edges, counting Baud_Update pulses seen
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (Baud_Update === 1'b1) upd_seen++;
    end
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  task automatic pulse_manual(input logic [15:0] b);
    Manual_Baud = b;
    Manual_Load = 1'b1;
    tick(1);
    Manual_Load = 1'b0;
  endtask

  // Drive 0x55 up to and including the start of bit 7 (the 5th falling edge).
  // Segment index 0 is the start bit, index k is data bit k-1.
  task automatic send_sync(input int bl, input int short_idx, input int short_len);
    logic [7:0] pat;
    pat = 8'h55;
    for (int k = 0; k < 9; k++) begin
      Rx = (k == 0) ? 1'b0 : pat[k-1];
      if (k < 8) tick((k == short_idx) ? short_len : bl);
    end
  endtask

  task automatic finish_frame(input int bl);
    tick(bl);
    Rx = 1'b1;
    tick(bl + 10);
  endtask

  initial begin
    Rst_n = 1'b0; Rx = 1'b1; Start = 1'b0; Manual_Load = 1'b0; Manual_Baud = 16'd0;
    tick(3);
    Rst_n = 1'b1;
    tick(2);

    // Reset state
    chk("rst_baud",   32'(BaudRate),    32'd27);
    chk("rst_locked", 32'(Locked),      32'd0);
    chk("rst_busy",   32'(Busy),        32'd0);
    chk("rst_error",  32'(Error),       32'd0);
    chk("rst_update", 32'(Baud_Update), 32'd0);

    // Nominal 434 clk/bit: total 3472, div (3472+64)>>7 = 27
    pulse_start();
    chk("arm_busy", 32'(Busy), 32'd1);
    tick(2);
    upd_seen = 0;
    send_sync(434, -1, 0);
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk("nom_update_timing", 32'(Baud_Update), (i == 4) ? 32'd1 : 32'd0);
    end
    tick(434 - 6);
    Rx = 1'b1;
    tick(444);
    chk("nom_update_count", 32'(upd_seen), 32'd1);
    chk("nom_baud",   32'(BaudRate), 32'd27);
    chk("nom_locked", 32'(Locked),   32'd1);
    chk("nom_busy",   32'(Busy),     32'd0);
    chk("nom_error",  32'(Error),    32'd0);

    // d3 shortened to 300, outside 326..542
    pulse_start();
    chk("rearm_locked", 32'(Locked), 32'd0);
    tick(2);
    send_sync(434, 4, 300);
    finish_frame(434);
    chk("tol_error",  32'(Error),    32'd1);
    chk("tol_locked", 32'(Locked),   32'd0);
    chk("tol_baud",   32'(BaudRate), 32'd27);
    chk("tol_busy",   32'(Busy),     32'd0);

    // 4 clk/bit: div = (32+64)>>7 = 0
    pulse_start();
    chk("arm_clr_error", 32'(Error), 32'd0);
    chk("arm_busy2",     32'(Busy),  32'd1);
    tick(2);
    send_sync(4, -1, 0);
    finish_frame(4);
    chk("div0_error",  32'(Error),    32'd1);
    chk("div0_locked", 32'(Locked),   32'd0);
    chk("div0_baud",   32'(BaudRate), 32'd27);

    // 8 clk/bit: div = (64+64)>>7 = 1; a second Start while waiting is ignored
    pulse_start();
    tick(1);
    pulse_start();
    chk("busy_start_ignored", 32'(Busy), 32'd1);
    send_sync(8, -1, 0);
    finish_frame(8);
    chk("div1_baud",   32'(BaudRate), 32'd1);
    chk("div1_locked", 32'(Locked),   32'd1);
    chk("div1_error",  32'(Error),    32'd0);

    // Manual load of 5 aborts a measurement in progress
    pulse_start();
    tick(2);
    Rx = 1'b0;
    tick(434);
    Rx = 1'b1;
    tick(200);
    chk("meas_busy", 32'(Busy), 32'd1);
    upd_seen = 0;
    pulse_manual(16'd5);
    chk("man_update", 32'(Baud_Update), 32'd1);
    chk("man_baud",   32'(BaudRate),    32'd5);
    chk("man_locked", 32'(Locked),      32'd1);
    chk("man_busy",   32'(Busy),        32'd0);
    chk("man_error",  32'(Error),       32'd0);
    tick(1);
    chk("man_update_off", 32'(Baud_Update), 32'd0);
    for (int k = 0; k < 8; k++) begin
      Rx = ~Rx;
      tick(434);
    end
    tick(10);
    chk("man_ignore_updates", 32'(upd_seen), 32'd1);
    chk("man_ignore_baud",    32'(BaudRate), 32'd5);
    chk("man_ignore_locked",  32'(Locked),   32'd1);

    // Manual divisor 0 is rejected, BaudRate held
    pulse_manual(16'd0);
    chk("man0_error",  32'(Error),       32'd1);
    chk("man0_locked", 32'(Locked),      32'd0);
    chk("man0_baud",   32'(BaudRate),    32'd5);
    chk("man0_update", 32'(Baud_Update), 32'd0);

    // Manual_Load and Start together: load wins, Start dropped
    Start = 1'b1;
    pulse_manual(16'd13);
    Start = 1'b0;
    chk("both_baud",   32'(BaudRate), 32'd13);
    chk("both_locked", 32'(Locked),   32'd1);
    chk("both_error",  32'(Error),    32'd0);
    tick(3);
    chk("both_busy",   32'(Busy),     32'd0);

    // Same divisor again still pulses Baud_Update
    pulse_manual(16'd13);
    chk("same_update", 32'(Baud_Update), 32'd1);

    // Asynchronous reset in the middle of a measurement
    pulse_start();
    tick(2);
    Rx = 1'b0;
    tick(100);
    chk("pre_rst_busy", 32'(Busy),     32'd1);
    chk("pre_rst_baud", 32'(BaudRate), 32'd13);
    Rst_n = 1'b0;
    #1;
    chk("arst_baud",   32'(BaudRate), 32'd27);
    chk("arst_locked", 32'(Locked),   32'd0);
    chk("arst_busy",   32'(Busy),     32'd0);
    chk("arst_error",  32'(Error),    32'd0);
    tick(2);
    Rst_n = 1'b1;
    Rx = 1'b1;
    tick(5);
    upd_seen = 0;
    send_sync(434, -1, 0);
    finish_frame(434);
    chk("idle_rx_updates", 32'(upd_seen), 32'd0);
    chk("idle_rx_baud",    32'(BaudRate), 32'd27);
    chk("idle_rx_locked",  32'(Locked),   32'd0);
    chk("idle_rx_busy",    32'(Busy),     32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
